canny_nms: RTL and testbench
============================

// Module: canny_nms
// PURPOSE
//  Non-maximum suppression stage of the Canny pipeline; sits directly after sobel_top.
//  Consumes a raster stream of gradient magnitude (20b) plus quantised angle (2b).
//  Builds a 3x3 magnitude window with two line buffers.
//  Outputs the centre magnitude when it is a local maximum along the gradient direction, else 0.
// PARAMETERS
//  IMG_W  64  pixels per row (>=4)
//  IMG_H  64  rows per frame (>=3)
//  MAG_W  20  magnitude width; matches sobel out_data
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  in_valid   in   1      input beat valid
//  in_ready   out  1      stage can accept a beat
//  in_sof     in   1      with in_valid: beat is pixel (0,0)
//  in_mag     in   MAG_W  gradient magnitude
//  in_angle   in   2      0=E/W 1=NE/SW 2=N/S 3=NW/SE (sobel angle_calc code)
//  out_valid  out  1      output beat valid; no backpressure
//  out_sof    out  1      out beat is pixel (0,0)
//  out_mag    out  MAG_W  suppressed magnitude
// BEHAVIOUR
//  Reset: out_valid=0, out_sof=0, out_mag=0, in_ready=0; FSM=IDLE; col/row counters=0.
//  Line-buffer RAM is not reset; border masking hides stale contents.
//  Transfer: a beat is taken on in_valid&&in_ready.
//  FSM states and transitions:
//   IDLE: in_ready=1; ignore beats without in_sof; sof beat -> FILL.
//   FILL: first IMG_W+1 beats; no output.
//   RUN: each accepted beat emits one output on the next cycle.
//   FLUSH: after the last beat (IMG_H-1, IMG_W-1), in_ready=0.
//    Injects IMG_W+1 internal zero beats, one per cycle, to drain the last row.
//    Then goes to IDLE.
//  in_sof on an accepted beat in FILL/RUN aborts the frame: counters reload to (0,0), state FILL.
//   No outputs are emitted for the aborted remainder.
//  Window: pixel (r,c) is decided when beat (r+1,c+1) is accepted; out_valid follows 1 cycle later.
//  Steady-state latency: IMG_W+2 cycles from in (r,c) to out (r,c).
//  Centre angle travels with magnitude: line buffers store {angle,mag}, 22 bits.
//  Neighbour pair by angle (row index grows downward):
//   0=(r,c-1),(r,c+1); 1=(r-1,c+1),(r+1,c-1); 2=(r-1,c),(r+1,c); 3=(r-1,c-1),(r+1,c+1).
//  Keep rule: out_mag = centre if centre>=n1 && centre>=n2, else 0.
//   Unsigned compare; ties keep the pixel.
//  Border pixels (r==0, r==IMG_H-1, c==0, c==IMG_W-1) always output 0.
//   This also masks column wrap-around inside the window.
//  out_sof=1 only with out_valid for pixel (0,0). Exactly IMG_W*IMG_H outputs per unaborted frame.
//  Input gaps (in_valid=0) stall the window; no output is produced for a stalled cycle.
// CONFIGURATION
//  CANNY_NMS_THRESH_EN defined: adds ports thr_lo, thr_hi (in, MAG_W) and out_class (out, 2).
//   out_class = 2 if out_mag>=thr_hi; 1 if out_mag>=thr_lo; else 0.
//   out_class is registered with out_mag and resets to 0.
//  CANNY_NMS_THRESH_EN undefined: those ports and the compare logic are absent.
// STRUCTURE
//  canny_pkg: MAG_W default, ANG_W=2, DIR_EW/DIR_NESW/DIR_NS/DIR_NWSE codes.
//   Also holds the FSM state encoding and the CLASS_NONE/WEAK/STRONG codes.
//  Sub-module canny_line_buf: IMG_W-deep, 22b-wide delay line with a single write/read pointer.
//   Advances only on an enable. Instantiated twice.
//  Top level holds the FSM, row/column counters, the 3x3 window registers and the compare/mux.
// TESTING
//  1. Flat frame, all mag=100, angle=0 -> interior out_mag=100 (ties kept), border=0, 4096 outputs.
//  2. Single 500 at (10,10) on a 0 field, each angle -> out (10,10)=500, all others 0.
//  3. Vertical ridge: col 20 mag=300, cols 19/21 mag=200, angle=0 -> only col 20 interior nonzero.
//     Repeat with angle=2 -> cols 19-21 all kept.
//  4. Random in_valid gaps (30%) vs gapless run of the same frame -> identical output sequence.
//     out_sof on the first output in both runs.
//  5. in_sof at beat 1000 mid-frame -> counters restart, next out_sof at IMG_W+2 accepted beats later.
//     Then exactly 4096 more outputs.
//  6. rst asserted mid-RUN for 1 cycle -> out_valid=0 next cycle, state IDLE, beats without in_sof ignored.
//     With CANNY_NMS_THRESH_EN: thr_lo=150, thr_hi=400, kept 500/200/100 -> class 2/1/0.

Source files
------------

// File: rtl/canny_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | canny_pkg: shared widths, direction/class codes and NMS state encoding.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package canny_pkg;

  localparam int DEF_MAG_W = 20;
  localparam int ANG_W     = 2;

  localparam logic [ANG_W-1:0] DIR_EW   = 2'd0;
  localparam logic [ANG_W-1:0] DIR_NESW = 2'd1;
  localparam logic [ANG_W-1:0] DIR_NS   = 2'd2;
  localparam logic [ANG_W-1:0] DIR_NWSE = 2'd3;

  localparam logic [1:0] CLASS_NONE   = 2'd0;
  localparam logic [1:0] CLASS_WEAK   = 2'd1;
  localparam logic [1:0] CLASS_STRONG = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } nms_state_t;

endpackage
`default_nettype wire

// File: rtl/canny_line_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | canny_line_buf: DEPTH-entry delay line, one shared read/write pointer.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module canny_line_buf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int              c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw-1:0] c_last = c_aw'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_ptr;

  // Read-before-write at the same slot gives exactly DEPTH enables of delay.
  assign dout = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (en) begin
      r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + c_aw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      r_mem[r_ptr] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/canny_nms.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | canny_nms: 3x3 non-maximum suppression on a {angle,mag} raster stream.   |
// | CANNY_NMS_THRESH_EN adds thr_lo/thr_hi inputs and the out_class output.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module canny_nms
  import canny_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int MAG_W = DEF_MAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [ANG_W-1:0] in_angle,
`ifdef CANNY_NMS_THRESH_EN
  input  logic [MAG_W-1:0] thr_lo,
  input  logic [MAG_W-1:0] thr_hi,
  output logic [1:0]       out_class,
`endif
  output logic             out_valid,
  output logic             out_sof,
  output logic [MAG_W-1:0] out_mag
);

  localparam int c_col_w = $clog2(IMG_W);
  localparam int c_row_w = $clog2(IMG_H);
  localparam int c_fl_w  = $clog2(IMG_W + 2);
  localparam int c_pw    = ANG_W + MAG_W;
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);
  localparam logic [c_fl_w-1:0]  c_fl_init  = c_fl_w'(IMG_W + 1);

  nms_state_t         r_state;
  logic               r_in_ready, r_out_valid, r_out_sof;
  logic [MAG_W-1:0]   r_out_mag;
  logic [c_col_w-1:0] r_col, r_ccol;
  logic [c_row_w-1:0] r_row, r_crow;
  logic [c_fl_w-1:0]  r_flush;

  // Window keeps the left and centre columns; the right column is the new beat.
  logic [MAG_W-1:0]   r_wa [3];
  logic [MAG_W-1:0]   r_wb [3];
  logic [ANG_W-1:0]   r_cang;
  logic [c_pw-1:0]    w_new [3];
  logic [MAG_W-1:0]   w_rmag [3];
  logic [c_pw-1:0]    w_lb1, w_lb2;
  logic               w_accept, w_flush, w_restart, w_push, w_emit, w_border;
  logic [MAG_W-1:0]   w_n1, w_n2, w_kept;
  logic               w_unused_ang;

  always_comb begin
    w_accept  = in_valid && r_in_ready;
    w_flush   = (r_state == ST_FLUSH);
    w_restart = w_accept && in_sof;
    w_push    = w_flush || (w_accept && (r_state != ST_IDLE || in_sof));
    w_emit    = w_flush || (r_state == ST_RUN && w_accept && !in_sof);
    w_new[2]  = w_flush ? '0 : {in_angle, in_mag};
    w_new[1]  = w_lb1;
    w_new[0]  = w_lb2;
    for (int i = 0; i < 3; i++) w_rmag[i] = w_new[i][MAG_W-1:0];
  end

  assign w_unused_ang = ^w_lb2[c_pw-1:MAG_W];

  canny_line_buf #(.DEPTH(IMG_W), .WIDTH(c_pw)) u_lb1 (
    .clk(clk), .rst(rst), .en(w_push), .din(w_new[2]), .dout(w_lb1)
  );
  canny_line_buf #(.DEPTH(IMG_W), .WIDTH(c_pw)) u_lb2 (
    .clk(clk), .rst(rst), .en(w_push), .din(w_lb1), .dout(w_lb2)
  );

  // Row 0 of the window is the row above the centre, row 2 the row below.
  always_comb begin
    w_n1 = r_wa[1];
    w_n2 = w_rmag[1];
    case (r_cang)
      DIR_EW:   begin w_n1 = r_wa[1];   w_n2 = w_rmag[1]; end
      DIR_NESW: begin w_n1 = w_rmag[0]; w_n2 = r_wa[2];   end
      DIR_NS:   begin w_n1 = r_wb[0];   w_n2 = r_wb[2];   end
      DIR_NWSE: begin w_n1 = r_wa[0];   w_n2 = w_rmag[2]; end
      default:  begin w_n1 = r_wa[1];   w_n2 = w_rmag[1]; end
    endcase
    w_border = (r_crow == '0) || (r_crow == c_row_last) ||
               (r_ccol == '0) || (r_ccol == c_col_last);
    w_kept   = (!w_border && r_wb[1] >= w_n1 && r_wb[1] >= w_n2) ? r_wb[1] : '0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = 0; i < 3; i++) begin
        r_wa[i] <= r_wb[i];
        r_wb[i] <= w_rmag[i];
      end
      r_cang <= w_new[1][c_pw-1:MAG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_mag   <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_ccol      <= '0;
      r_crow      <= '0;
      r_flush     <= '0;
    end else begin
      r_out_valid <= w_emit;
      r_out_sof   <= w_emit && (r_crow == '0) && (r_ccol == '0);
      if (w_emit) begin
        r_out_mag <= w_kept;
        if (r_ccol == c_col_last) begin
          r_ccol <= '0;
          r_crow <= (r_crow == c_row_last) ? '0 : r_crow + c_row_w'(1);
        end else begin
          r_ccol <= r_ccol + c_col_w'(1);
        end
      end
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_restart) begin
            r_col   <= c_col_w'(1);
            r_row   <= '0;
            r_ccol  <= '0;
            r_crow  <= '0;
            r_state <= ST_FILL;
          end
        end
        ST_FILL, ST_RUN: begin
          if (w_restart) begin
            r_col   <= c_col_w'(1);
            r_row   <= '0;
            r_ccol  <= '0;
            r_crow  <= '0;
            r_state <= ST_FILL;
          end else if (w_accept) begin
            if (r_col == c_col_last) begin
              r_col <= '0;
              r_row <= r_row + c_row_w'(1);
            end else begin
              r_col <= r_col + c_col_w'(1);
            end
            // IMG_W+1 beats fill the window; the beat at (1,0) is the last of them.
            if (r_state == ST_FILL && r_row == c_row_w'(1) && r_col == '0) begin
              r_state <= ST_RUN;
            end
            if (r_state == ST_RUN && r_row == c_row_last && r_col == c_col_last) begin
              r_state    <= ST_FLUSH;
              r_in_ready <= 1'b0;
              r_flush    <= c_fl_init;
              r_row      <= '0;
            end
          end
        end
        ST_FLUSH: begin
          r_flush <= r_flush - c_fl_w'(1);
          if (r_flush == c_fl_w'(1)) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_mag   = r_out_mag;

`ifdef CANNY_NMS_THRESH_EN
  logic [1:0] r_class;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_class <= CLASS_NONE;
    end else if (w_emit) begin
      r_class <= (w_kept >= thr_hi) ? CLASS_STRONG :
                 (w_kept >= thr_lo) ? CLASS_WEAK : CLASS_NONE;
    end
  end

  assign out_class = r_class;
`endif

endmodule
`default_nettype wire

// File: tb/tb_canny_nms.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_canny_nms: directed frames for canny_nms checked against an NMS model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_canny_nms;
  import canny_pkg::*;

  localparam int W  = 64;
  localparam int H  = 64;
  localparam int N  = W * H;
  localparam int MW = 20;
  localparam int CAP = 65536;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [MW-1:0] in_mag = '0;
  logic [1:0]    in_angle = '0;
  logic          in_ready, out_valid, out_sof;
  logic [MW-1:0] out_mag;
`ifdef CANNY_NMS_THRESH_EN
  logic [MW-1:0] thr_lo = '0;
  logic [MW-1:0] thr_hi = '0;
  logic [1:0]    out_class;
  logic [1:0]    cap_cls [CAP];
`endif

  canny_nms #(.IMG_W(W), .IMG_H(H), .MAG_W(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_mag(in_mag), .in_angle(in_angle),
`ifdef CANNY_NMS_THRESH_EN
    .thr_lo(thr_lo), .thr_hi(thr_hi), .out_class(out_class),
`endif
    .out_valid(out_valid), .out_sof(out_sof), .out_mag(out_mag)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ocnt = 0, cyc = 0, sof_cyc = 0;
  int fbase = 0, t_sof_acc = 0;
  logic [MW-1:0] img_mag [N];
  logic [1:0]    img_ang [N];
  logic [MW-1:0] cap_mag [CAP];
  logic          cap_sof [CAP];
  logic [MW-1:0] gold    [N];

  typedef struct {
    int kind;
    int ang;
    int r;
    int c;
    int exp;
  } vec_t;
  vec_t tbl [18];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      if (ocnt < CAP) begin
        cap_mag[ocnt] <= out_mag;
        cap_sof[ocnt] <= out_sof;
`ifdef CANNY_NMS_THRESH_EN
        cap_cls[ocnt] <= out_class;
`endif
      end
      if (out_sof) sof_cyc <= cyc;
      ocnt <= ocnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // kind: 0 flat, 1 single spot, 2 vertical ridge, 3 random, 4 threshold spots
  task automatic build_frame(input int kind, input int ang);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int m;
        m = 0;
        case (kind)
          0: m = 100;
          1: m = (r == 10 && c == 10) ? 500 : 0;
          2: m = (c == 20) ? 300 : ((c == 19 || c == 21) ? 200 : 0);
          3: m = int'($urandom_range(0, 1023));
          default: m = (r == 10 && c == 10) ? 500 :
                       (r == 20 && c == 20) ? 200 :
                       (r == 30 && c == 30) ? 100 : 0;
        endcase
        img_mag[r*W+c] = MW'(m);
        img_ang[r*W+c] = (kind == 3) ? 2'($urandom_range(0, 3)) : 2'(ang);
      end
    end
  endtask

  function automatic int mg(int r, int c);
    return int'(img_mag[r*W+c]);
  endfunction

  function automatic int ref_px(int r, int c);
    int m, n1, n2;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    m = mg(r, c);
    case (img_ang[r*W+c])
      2'd0:    begin n1 = mg(r, c-1);   n2 = mg(r, c+1);   end
      2'd1:    begin n1 = mg(r-1, c+1); n2 = mg(r+1, c-1); end
      2'd2:    begin n1 = mg(r-1, c);   n2 = mg(r+1, c);   end
      default: begin n1 = mg(r-1, c-1); n2 = mg(r+1, c+1); end
    endcase
    return (m >= n1 && m >= n2) ? m : 0;
  endfunction

  task automatic send_beat(input logic sof, input int p, input int gap_pct);
    int w;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_sof   = sof;
    in_mag   = img_mag[p];
    in_angle = img_ang[p];
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic run_frame(input int gap_pct);
    int w, nsof, bad;
    send_beat(1'b1, 0, gap_pct);
    t_sof_acc = cyc;
    fbase = ocnt;
    for (int p = 1; p < N; p++) send_beat(1'b0, p, gap_pct);
    w = 0;
    while (ocnt - fbase < N && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (W + 10) @(posedge clk);
    #1;
    chk("out_count", ocnt - fbase, N);
    nsof = 0;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (cap_sof[fbase+i]) nsof++;
      if (int'(cap_mag[fbase+i]) != ref_px(i / W, i % W)) bad++;
    end
    chk("sof_first", int'(cap_sof[fbase]), 1);
    chk("sof_count", nsof, 1);
    chk("frame_vs_model", bad, 0);
  endtask

  initial begin
    int lk, la, bad, b;

    tbl[0]  = '{0, 0, 10, 10, 100};
    tbl[1]  = '{0, 0, 0, 5, 0};
    tbl[2]  = '{0, 0, 63, 30, 0};
    tbl[3]  = '{0, 0, 5, 0, 0};
    tbl[4]  = '{0, 0, 5, 63, 0};
    tbl[5]  = '{0, 0, 62, 62, 100};
    tbl[6]  = '{0, 0, 1, 1, 100};
    tbl[7]  = '{1, 0, 10, 10, 500};
    tbl[8]  = '{1, 0, 10, 11, 0};
    tbl[9]  = '{1, 1, 10, 10, 500};
    tbl[10] = '{1, 2, 10, 10, 500};
    tbl[11] = '{1, 3, 10, 10, 500};
    tbl[12] = '{2, 0, 30, 20, 300};
    tbl[13] = '{2, 0, 30, 19, 0};
    tbl[14] = '{2, 0, 30, 21, 0};
    tbl[15] = '{2, 2, 30, 19, 200};
    tbl[16] = '{2, 2, 30, 20, 300};
    tbl[17] = '{2, 2, 0, 20, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sof", int'(out_sof), 0);
    chk("rst_out_mag", int'(out_mag), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", int'(in_ready), 1);

    lk = -1;
    la = -1;
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].kind != lk || tbl[i].ang != la) begin
        build_frame(tbl[i].kind, tbl[i].ang);
        run_frame(0);
        lk = tbl[i].kind;
        la = tbl[i].ang;
      end
      chk($sformatf("px_k%0d_a%0d_r%0d_c%0d", tbl[i].kind, tbl[i].ang, tbl[i].r, tbl[i].c),
          int'(cap_mag[fbase + tbl[i].r*W + tbl[i].c]), tbl[i].exp);
    end

    // Same random frame, gapless then with ~30% idle cycles.
    build_frame(3, 0);
    run_frame(0);
    for (int i = 0; i < N; i++) gold[i] = cap_mag[fbase+i];
    run_frame(30);
    bad = 0;
    for (int i = 0; i < N; i++) if (cap_mag[fbase+i] != gold[i]) bad++;
    chk("gap_vs_gapless", bad, 0);

    // Abort after 1000 beats; the new sof beat restarts the frame.
    build_frame(3, 0);
    for (int p = 0; p < 1000; p++) send_beat(p == 0, p, 0);
    run_frame(0);
    chk("abort_sof_latency", sof_cyc - t_sof_acc, W + 1);

    // One-cycle reset in the middle of a run.
    build_frame(3, 0);
    for (int p = 0; p < 2000; p++) send_beat(p == 0, p, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle_ready", int'(in_ready), 1);
    b = ocnt;
    for (int p = 0; p < 100; p++) send_beat(1'b0, p + 1, 0);
    repeat (W + 10) @(posedge clk);
    #1;
    chk("idle_ignores_nosof", ocnt - b, 0);
    run_frame(0);

`ifdef CANNY_NMS_THRESH_EN
    thr_lo = MW'(150);
    thr_hi = MW'(400);
    build_frame(4, 0);
    run_frame(0);
    chk("cls_500", int'(cap_cls[fbase + 10*W + 10]), 2);
    chk("cls_200", int'(cap_cls[fbase + 20*W + 20]), 1);
    chk("cls_100", int'(cap_cls[fbase + 30*W + 30]), 0);
    chk("mag_100", int'(cap_mag[fbase + 30*W + 30]), 100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
